// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 SEQ controller:
// instruction codes, status codes and sequencer states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_t;

  function automatic logic is_mem_icode(
    input logic [3:0] ic
  );
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) ||
           (ic == ICALL)   || (ic == IRET)    ||
           (ic == IPUSHQ)  || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_next_pc.sv
// Combinational next-PC select: call and taken jumps
// go to valC, ret to valM, everything else falls through.
module y86_next_pc
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic [3:0]        i_icode,
  input  logic              i_cnd,
  input  logic [WORD_W-1:0] i_valC,
  input  logic [WORD_W-1:0] i_valP,
  input  logic [WORD_W-1:0] i_valM,
  output logic [WORD_W-1:0] o_next_pc
);

  logic w_to_valc;
  logic w_to_valm;

  assign w_to_valc = (i_icode == ICALL) ||
                     ((i_icode == IJXX) && i_cnd);
  assign w_to_valm = (i_icode == IRET);

  always_comb begin
    o_next_pc = i_valP;
    unique case (1'b1)
      w_to_valc: o_next_pc = i_valC;
      w_to_valm: o_next_pc = i_valM;
      default:   o_next_pc = i_valP;
    endcase
  end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle SEQ sequencer: steps FETCH..PCUPD, owns
// the architectural PC, status code and retire counter.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int                WORD_W      = 64,
  parameter int                CNT_W       = 32,
  parameter logic [WORD_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [WORD_W-1:0] valC,
  input  logic [WORD_W-1:0] valP,
  input  logic [WORD_W-1:0] valM,
  input  logic              imem_error,
  input  logic              func_error,
  input  logic              dmem_ready,
  input  logic              dmem_error,
  output logic [WORD_W-1:0] pc,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              execute_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              set_cc,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t             r_state;
  state_t             w_next;
  logic [TW-1:0]      r_wait;
  logic [WORD_W-1:0]  r_pc;
  logic [2:0]         r_stat;
  logic [CNT_W-1:0]   r_cnt;

  logic [WORD_W-1:0]  w_npc;
  logic               w_mem_op;
  logic               w_tmo;
  logic               w_restart;
  logic               w_set_stat;
  logic [2:0]         w_fault_stat;

  y86_next_pc #(
    .WORD_W (WORD_W)
  ) u_next_pc (
    .i_icode   (icode),
    .i_cnd     (cnd),
    .i_valC    (valC),
    .i_valP    (valP),
    .i_valM    (valM),
    .o_next_pc (w_npc)
  );

  assign w_mem_op  = is_mem_icode(icode);
  assign w_tmo     = (r_wait == TW'(MEM_TIMEOUT - 1));
  assign w_restart = start &&
                     ((r_state == S_IDLE) ||
                      (r_state == S_HALTED));

  always_comb begin
    w_next       = r_state;
    w_set_stat   = 1'b0;
    w_fault_stat = SAOK;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_next = S_DECODE;
        // fault priority: address, then encoding, then halt
        if (imem_error) begin
          w_next       = S_HALTED;
          w_set_stat   = 1'b1;
          w_fault_stat = SADR;
        end else if (func_error) begin
          w_next       = S_HALTED;
          w_set_stat   = 1'b1;
          w_fault_stat = SINS;
        end else if (icode == IHALT) begin
          w_next       = S_HALTED;
          w_set_stat   = 1'b1;
          w_fault_stat = SHLT;
        end
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_MEMORY;
      S_MEMORY: begin
        if (!w_mem_op) begin
          w_next = S_WRITEBACK;
        end else if (dmem_ready) begin
          if (dmem_error) begin
            w_next       = S_HALTED;
            w_set_stat   = 1'b1;
            w_fault_stat = SADR;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (w_tmo) begin
          w_next       = S_HALTED;
          w_set_stat   = 1'b1;
          w_fault_stat = SADR;
        end
      end
      S_WRITEBACK: w_next = S_PCUPD;
      S_PCUPD:     w_next = S_FETCH;
      S_HALTED: begin
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_pc    <= RESET_PC;
      r_stat  <= SAOK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_MEMORY) begin
        r_wait <= r_wait + TW'(1);
      end else begin
        r_wait <= '0;
      end
      if (w_set_stat) begin
        r_stat <= w_fault_stat;
      end
      if (w_restart) begin
        r_pc   <= RESET_PC;
        r_stat <= SAOK;
      end
      if (r_state == S_PCUPD) begin
        r_pc <= w_npc;
        if (!(&r_cnt)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign fetch_en    = (r_state == S_FETCH);
  assign decode_en   = (r_state == S_DECODE);
  assign execute_en  = (r_state == S_EXECUTE);
  assign mem_en      = (r_state == S_MEMORY);
  assign wb_en       = (r_state == S_WRITEBACK);
  assign set_cc      = (r_state == S_EXECUTE) &&
                       (icode == IOPQ);
  assign halted      = (r_state == S_HALTED);
  assign pc          = r_pc;
  assign stat        = r_stat;
  assign instr_count = r_cnt;

endmodule
